// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the RV32M multiply sequencer.
//   XLEN     : operand width
//   mul_op_e : funct3[1:0] encodings of MUL/MULH/MULHSU/MULHU
//   state_e  : sequencer FSM states
package mul_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_BUSY  = 2'b10,
        S_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/mul_ctrl_if.sv
// Handshake between the sequencer and the iterative unsigned multiplier.
//   mul_start  : one-cycle start pulse       (ctrl -> mult)
//   mul_cancel : one-cycle abort             (ctrl -> mult)
//   mul_signed : negate the final product    (ctrl -> mult)
//   mul_op1/2  : operand magnitudes          (ctrl -> mult)
//   mul_stop   : done; results valid now     (mult -> ctrl)
//   mul_res_l/h: sign-corrected product halves (mult -> ctrl)
interface mul_ctrl_if;
    import mul_ctrl_pkg::*;

    logic            mul_start;
    logic            mul_cancel;
    logic            mul_signed;
    logic [XLEN-1:0] mul_op1;
    logic [XLEN-1:0] mul_op2;
    logic            mul_stop;
    logic [XLEN-1:0] mul_res_l;
    logic [XLEN-1:0] mul_res_h;

    modport master (
        output mul_start, mul_cancel, mul_signed, mul_op1, mul_op2,
        input  mul_stop, mul_res_l, mul_res_h
    );

    modport slave (
        input  mul_start, mul_cancel, mul_signed, mul_op1, mul_op2,
        output mul_stop, mul_res_l, mul_res_h
    );
endinterface

// File: rtl/mul_sign_fix.sv
// Converts RV32M operands to sign-magnitude form.
//   op_i         : funct3[1:0]
//   rs1_i, rs2_i : raw operands
//   abs1_o/abs2_o: magnitudes (unsigned; the most negative value maps to itself)
//   neg_o        : product must be negated
module mul_sign_fix
    import mul_ctrl_pkg::*;
(
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] abs1_o,
    output logic [XLEN-1:0] abs2_o,
    output logic            neg_o
);
    logic s1, s2, n1, n2;

    // rs1 is signed for MULH/MULHSU, rs2 only for MULH
    assign s1 = (op_i == MUL_OP_MULH) || (op_i == MUL_OP_MULHSU);
    assign s2 = (op_i == MUL_OP_MULH);
    assign n1 = s1 & rs1_i[XLEN-1];
    assign n2 = s2 & rs2_i[XLEN-1];

    assign abs1_o = n1 ? (~rs1_i + 1'b1) : rs1_i;
    assign abs2_o = n2 ? (~rs2_i + 1'b1) : rs2_i;
    assign neg_o  = n1 ^ n2;
endmodule

// File: rtl/mul_ctrl.sv
// EX-stage sequencer for RV32M multiplies. Accepts an op from EX, drives the
// iterative multiplier through mul_if, stalls the front end while it runs and
// presents the selected product half with its rd.
//   clk, rst_n        : clock, async active-low reset
//   mul_req_i/op/rs/rd: request from EX (held while stall_o)
//   flush_i           : kill the in-flight op
//   hold_i            : downstream stall, keep result presented
//   mul_if (master)   : multiplier handshake
//   stall_o           : freeze IF/ID/EX
//   wb_valid_o/data/rd: result to EX->MEM
module mul_ctrl
    import mul_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_req_i,
    input  logic [1:0]      mul_op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    input  logic            hold_i,
    mul_ctrl_if.master      mul_if,
    output logic            stall_o,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      wb_rd_o
);
    state_e          state_q, state_d;
    logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
    logic            neg_q, neg_d;
    logic [1:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;

    logic [XLEN-1:0] abs1, abs2;
    logic            neg, is_zero;
    logic            stall, start, cancel, wb_valid;

    mul_sign_fix u_sign_fix (
        .op_i   (mul_op_i),
        .rs1_i  (rs1_data_i),
        .rs2_i  (rs2_data_i),
        .abs1_o (abs1),
        .abs2_o (abs2),
        .neg_o  (neg)
    );

    assign is_zero = (rs1_data_i == '0) || (rs2_data_i == '0);

    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        neg_d    = neg_q;
        op_d     = op_q;
        rd_d     = rd_q;
        res_d    = res_q;
        stall    = 1'b0;
        start    = 1'b0;
        cancel   = 1'b0;
        wb_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mul_req_i && !flush_i) begin
                    stall = 1'b1;
                    rd_d  = rd_addr_i;
                    op_d  = mul_op_i;
                    if (is_zero) begin
                        // product is zero whatever the signs; skip the multiplier
                        res_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        op1_d   = abs1;
                        op2_d   = abs2;
                        neg_d   = neg;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                stall = 1'b1;
                if (flush_i) begin
                    cancel  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    start   = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                // flush wins over a coincident stop
                if (flush_i) begin
                    cancel  = 1'b1;
                    state_d = S_IDLE;
                end else if (mul_if.mul_stop) begin
                    res_d   = (op_q == MUL_OP_MUL) ? mul_if.mul_res_l : mul_if.mul_res_h;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                wb_valid = !flush_i;
                if (flush_i || !hold_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            neg_q   <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            neg_q   <= neg_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
        end
    end

    // stall is combinational from the request, so gate it while reset is held
    assign stall_o           = stall & rst_n;
    assign wb_valid_o        = wb_valid;
    assign wb_data_o         = res_q;
    assign wb_rd_o           = rd_q;
    assign mul_if.mul_start  = start;
    assign mul_if.mul_cancel = cancel;
    assign mul_if.mul_signed = neg_q;
    assign mul_if.mul_op1    = op1_q;
    assign mul_if.mul_op2    = op2_q;
endmodule

// File: tb/tb_mul_ctrl.sv
module tb_mul_ctrl;
    import mul_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mul_req_i;
    logic [1:0]  mul_op_i;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i, hold_i;
    logic        stall_o, wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;

    mul_ctrl_if mif();

    mul_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mul_req_i  (mul_req_i),
        .mul_op_i   (mul_op_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .flush_i    (flush_i),
        .hold_i     (hold_i),
        .mul_if     (mif),
        .stall_o    (stall_o),
        .wb_valid_o (wb_valid_o),
        .wb_data_o  (wb_data_o),
        .wb_rd_o    (wb_rd_o)
    );

    always #5 clk = ~clk;

    // Multiplier model: XLEN iterations after the start cycle, stop for one cycle.
    logic        m_busy;
    int          m_cnt;
    logic [63:0] m_p, m_prod;
    assign m_prod        = {32'b0, mif.mul_op1} * {32'b0, mif.mul_op2};
    assign mif.mul_stop  = m_busy && (m_cnt == 0);
    assign mif.mul_res_l = mif.mul_stop ? m_p[31:0]  : 32'hDEADBEEF;
    assign mif.mul_res_h = mif.mul_stop ? m_p[63:32] : 32'hDEADBEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_cnt <= 0; m_p <= '0;
        end else if (mif.mul_cancel) begin
            m_busy <= 1'b0;
        end else if (mif.mul_start) begin
            m_busy <= 1'b1; m_cnt <= 32;
            m_p    <= mif.mul_signed ? (~m_prod + 64'd1) : m_prod;
        end else if (m_busy) begin
            if (m_cnt == 0) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end
    end

    // Event counters (monotonic; tests take differences)
    int n_start = 0, n_cancel = 0, n_both = 0, n_retire = 0;
    always @(posedge clk) begin
        if (mif.mul_start)                n_start  <= n_start + 1;
        if (mif.mul_cancel)               n_cancel <= n_cancel + 1;
        if (mif.mul_start && mif.mul_cancel) n_both <= n_both + 1;
        if (wb_valid_o && !hold_i)        n_retire <= n_retire + 1;
    end

    int errors = 0, checks = 0;
    int r_lat, r_stall;
    logic [31:0] r_data;
    logic [4:0]  r_rd;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present an op at +1 of cycle T; return at +2 of the first wb_valid cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        mul_op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd; mul_req_i = 1'b1;
        r_lat = -1; r_stall = 0; r_data = '0; r_rd = '0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (wb_valid_o) begin r_lat = c; r_data = wb_data_o; r_rd = wb_rd_o; break; end
            if (stall_o) r_stall++;
            @(posedge clk); #1;
        end
        mul_req_i = 1'b0;
        if (r_lat < 0) begin
            checks++; errors++;
            $display("FAIL run_timeout op=%0d a=%h b=%h: no wb_valid_o within 100 cycles", op, a, b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mul_req_i = 1'b1; rs1_data_i = 32'd7; rs2_data_i = 32'd6;
        #12;
        checks++;
        if ({stall_o, wb_valid_o, wb_data_o, wb_rd_o, mif.mul_start, mif.mul_cancel,
             mif.mul_signed, mif.mul_op1, mif.mul_op2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs stall=%b wbv=%b data=%h rd=%0d start=%b cancel=%b sgn=%b op1=%h op2=%h, all required 0",
                     stall_o, wb_valid_o, wb_data_o, wb_rd_o, mif.mul_start, mif.mul_cancel,
                     mif.mul_signed, mif.mul_op1, mif.mul_op2);
        end
        mul_req_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mul_basic();
        int s0 = n_start;
        run_op(MUL_OP_MUL, 32'd7, 32'd6, 5'd5);
        checks++; if (r_lat !== 35) begin errors++; $display("FAIL mul_latency got=%0d exp=35", r_lat); end
        checks++; if (r_data !== 32'd42) begin errors++; $display("FAIL mul_data got=%h exp=%h", r_data, 32'd42); end
        checks++; if (r_rd !== 5'd5) begin errors++; $display("FAIL mul_rd got=%0d exp=5", r_rd); end
        checks++; if (r_stall !== 35) begin errors++; $display("FAIL mul_stall_cycles got=%0d exp=35", r_stall); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mul_stall_in_done got=%b exp=0", stall_o); end
        tick();
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL mul_single_valid got=%b exp=0", wb_valid_o); end
        checks++; if (n_start - s0 !== 1) begin errors++; $display("FAIL mul_start_count got=%0d exp=1", n_start - s0); end
    endtask

    task automatic test_signed();
        logic [1:0]  ops [7] = '{MUL_OP_MULH, MUL_OP_MULH, MUL_OP_MULHU, MUL_OP_MULHSU,
                                 MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MUL};
        logic [31:0] av  [7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] bv  [7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'hFFFFFFFF, 32'd6, 32'd6};
        logic [31:0] ev  [7] = '{32'h40000000, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFD6};
        for (int i = 0; i < 7; i++) begin
            run_op(ops[i], av[i], bv[i], 5'(i + 10));
            checks++;
            if (r_data !== ev[i] || r_rd !== 5'(i + 10)) begin
                errors++;
                $display("FAIL signed_vec%0d data=%h rd=%0d exp data=%h rd=%0d", i, r_data, r_rd, ev[i], i + 10);
            end
            if (i == 5) begin
                // MULH -7*6: magnitude 7 and negate flag stay on the multiplier port
                checks++;
                if (mif.mul_op1 !== 32'd7 || mif.mul_op2 !== 32'd6 || mif.mul_signed !== 1'b1) begin
                    errors++;
                    $display("FAIL signed_operands op1=%h op2=%h sgn=%b exp 7 6 1", mif.mul_op1, mif.mul_op2, mif.mul_signed);
                end
            end
            tick();
        end
    endtask

    task automatic test_zero();
        int s0 = n_start;
        run_op(MUL_OP_MUL, 32'd0, 32'h1234, 5'd9);
        checks++;
        if (r_lat !== 1 || r_data !== 32'd0 || r_rd !== 5'd9) begin
            errors++; $display("FAIL zero_rs1 lat=%0d data=%h rd=%0d exp 1 0 9", r_lat, r_data, r_rd);
        end
        tick();
        run_op(MUL_OP_MULHU, 32'hABCD, 32'd0, 5'd4);
        checks++;
        if (r_lat !== 1 || r_data !== 32'd0) begin
            errors++; $display("FAIL zero_rs2 lat=%0d data=%h exp 1 0", r_lat, r_data);
        end
        tick(); tick();
        checks++; if (n_start - s0 !== 0) begin errors++; $display("FAIL zero_no_start got=%0d exp=0", n_start - s0); end
    endtask

    task automatic test_flush();
        int c0 = n_cancel, s0 = n_start, bad = 0;
        // flush in IDLE: request ignored
        mul_op_i = MUL_OP_MUL; rs1_data_i = 32'd5; rs2_data_i = 32'd5; rd_addr_i = 5'd1;
        mul_req_i = 1'b1; flush_i = 1'b1; #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_idle_stall got=%b exp=0", stall_o); end
        tick(); mul_req_i = 1'b0; flush_i = 1'b0; #1;
        checks++; if (stall_o !== 1'b0 || n_start != s0) begin
            errors++; $display("FAIL flush_idle_accept stall=%b starts=%0d exp 0 0", stall_o, n_start - s0);
        end
        tick();
        // flush in START: cancel replaces start
        mul_req_i = 1'b1; rs1_data_i = 32'd100; rs2_data_i = 32'd3; rd_addr_i = 5'd3;
        tick(); flush_i = 1'b1; mul_req_i = 1'b0; #1;
        checks++; if (mif.mul_start !== 1'b0 || mif.mul_cancel !== 1'b1) begin
            errors++; $display("FAIL flush_start start=%b cancel=%b exp 0 1", mif.mul_start, mif.mul_cancel);
        end
        tick(); flush_i = 1'b0; #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_start_idle stall=%b exp=0", stall_o); end
        tick();
        // flush at T+10 (BUSY)
        mul_req_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        flush_i = 1'b1; mul_req_i = 1'b0; #1;
        checks++; if (mif.mul_cancel !== 1'b1 || mif.mul_start !== 1'b0) begin
            errors++; $display("FAIL flush_busy_cancel cancel=%b start=%b exp 1 0", mif.mul_cancel, mif.mul_start);
        end
        tick(); flush_i = 1'b0;
        for (int i = 0; i < 40; i++) begin tick(); if (wb_valid_o || stall_o) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL flush_no_wb got=%0d bad cycles exp=0", bad); end
        checks++; if (n_cancel - c0 !== 2) begin errors++; $display("FAIL flush_cancel_count got=%0d exp=2", n_cancel - c0); end
        run_op(MUL_OP_MUL, 32'd9, 32'd9, 5'd2);
        checks++; if (r_lat !== 35 || r_data !== 32'd81) begin
            errors++; $display("FAIL flush_recover lat=%0d data=%h exp 35 %h", r_lat, r_data, 32'd81);
        end
        tick();
    endtask

    task automatic test_hold();
        int r0 = n_retire, s0 = n_start, bad = 0;
        hold_i = 1'b1;
        run_op(MUL_OP_MULHU, 32'h00010000, 32'h00030000, 5'd7);
        checks++; if (r_lat !== 35 || r_data !== 32'd3 || r_rd !== 5'd7) begin
            errors++; $display("FAIL hold_result lat=%0d data=%h rd=%0d exp 35 3 7", r_lat, r_data, r_rd);
        end
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            if (wb_valid_o !== 1'b1 || wb_data_o !== 32'd3 || wb_rd_o !== 5'd7) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_stable got=%0d unstable cycles exp=0", bad); end
        tick(); hold_i = 1'b0; #1;
        checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL hold_release_valid got=%b exp=1", wb_valid_o); end
        tick(); #1;
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL hold_done_exit got=%b exp=0", wb_valid_o); end
        tick(); tick();
        checks++; if (n_retire - r0 !== 1 || n_start - s0 !== 1) begin
            errors++; $display("FAIL hold_single_retire retires=%0d starts=%0d exp 1 1", n_retire - r0, n_start - s0);
        end
    endtask

    task automatic test_reset_mid();
        mul_op_i = MUL_OP_MULH; rs1_data_i = 32'hFFFFFFF5; rs2_data_i = 32'd13; rd_addr_i = 5'd8;
        mul_req_i = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        #1; rst_n = 1'b0; #1;
        checks++;
        if ({stall_o, wb_valid_o, wb_data_o, wb_rd_o, mif.mul_start, mif.mul_cancel,
             mif.mul_signed, mif.mul_op1, mif.mul_op2} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs stall=%b wbv=%b data=%h rd=%0d start=%b cancel=%b sgn=%b op1=%h op2=%h, all required 0",
                     stall_o, wb_valid_o, wb_data_o, wb_rd_o, mif.mul_start, mif.mul_cancel,
                     mif.mul_signed, mif.mul_op1, mif.mul_op2);
        end
        mul_req_i = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick();
        run_op(MUL_OP_MUL, 32'd3, 32'd5, 5'd11);
        checks++; if (r_lat !== 35 || r_data !== 32'd15 || r_rd !== 5'd11) begin
            errors++; $display("FAIL reset_recover lat=%0d data=%h rd=%0d exp 35 f 11", r_lat, r_data, r_rd);
        end
        tick();
        checks++; if (n_both !== 0) begin errors++; $display("FAIL start_cancel_overlap got=%0d exp=0", n_both); end
    endtask

    initial begin
        mul_req_i = 1'b0; mul_op_i = '0; rs1_data_i = '0; rs2_data_i = '0; rd_addr_i = '0;
        flush_i = 1'b0; hold_i = 1'b0;
        test_reset();
        test_mul_basic();
        test_signed();
        test_zero();
        test_flush();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
